// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU memory-bus unit: FSM states, grants, fill values.
// Optional watchdog is enabled with BUS_TIMEOUT_EN.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RESP
  } state_t;

  typedef enum logic {
    GNT_IF,
    GNT_LS
  } grant_t;

  localparam logic RDATA_RST_BIT  = 1'b0;
  localparam logic ABORT_FILL_BIT = 1'b1;

endpackage

// File: rtl/cpu_bus_rr_arb.sv
// Two-way round-robin arbiter between fetch and load/store requests.
// A tie goes to the port that was not granted last.
module cpu_bus_rr_arb
  import cpu_bus_pkg::*;
(
  input  logic   req_if,
  input  logic   req_ls,
  input  grant_t last_grant,
  output grant_t grant,
  output logic   valid
);

  assign valid = req_if | req_ls;

  always_comb begin
    grant = GNT_IF;
    unique case (1'b1)
      req_if && req_ls:
        grant = (last_grant == GNT_IF) ? GNT_LS : GNT_IF;
      req_ls && !req_if:
        grant = GNT_LS;
      default:
        grant = GNT_IF;
    endcase
  end

endmodule

// File: rtl/cpu_bus_unit.sv
// Shared fetch + load/store memory bus with round-robin arbitration.
// Define BUS_TIMEOUT_EN to build the ack watchdog and err output.
module cpu_bus_unit
  import cpu_bus_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd_ctrl,
  output logic              mem_wr_ctrl,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err,
  output logic              busy
);

  state_t            state, state_nx;
  grant_t            gnt, last_grant, arb_gnt;
  logic              arb_valid;
  logic              we;
  logic              abort;
  logic              ls_store;
  logic [DATA_W-1:0] fill;

  cpu_bus_rr_arb u_arb (
    .req_if     (if_req),
    .req_ls     (ls_req),
    .last_grant (last_grant),
    .grant      (arb_gnt),
    .valid      (arb_valid)
  );

  assign ls_store = (arb_gnt == GNT_LS) && ls_we;
  assign fill = mem_ack ? mem_rdata
                        : {DATA_W{ABORT_FILL_BIT}};

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (arb_valid) state_nx = ACC;
      ACC:     if (mem_ack || abort) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= GNT_IF;
      last_grant  <= GNT_IF;
      we          <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_rd_ctrl <= 1'b0;
      mem_wr_ctrl <= 1'b0;
      if_done     <= 1'b0;
      ls_done     <= 1'b0;
      busy        <= 1'b0;
      if_rdata    <= {DATA_W{RDATA_RST_BIT}};
      ls_rdata    <= {DATA_W{RDATA_RST_BIT}};
    end else begin
      state   <= state_nx;
      busy    <= (state_nx != IDLE);
      if_done <= 1'b0;
      ls_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb_valid) begin
            gnt         <= arb_gnt;
            last_grant  <= arb_gnt;
            we          <= ls_store;
            mem_rd_ctrl <= !ls_store;
            mem_wr_ctrl <= ls_store;
            mem_addr    <= (arb_gnt == GNT_LS) ? ls_addr
                                               : if_addr;
            if (ls_store) mem_wdata <= ls_wdata;
          end
        end
        ACC: begin
          if (mem_ack || abort) begin
            mem_rd_ctrl <= 1'b0;
            mem_wr_ctrl <= 1'b0;
            if (gnt == GNT_LS) ls_done <= 1'b1;
            else               if_done <= 1'b1;
            // stores leave the read-data registers untouched
            if (!we) begin
              if (gnt == GNT_LS) ls_rdata <= fill;
              else               if_rdata <= fill;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // a same-cycle ack wins over the watchdog
  assign abort = (state == ACC) && !mem_ack &&
                 (wd_cnt == 16'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      err <= abort;
      if (state != ACC) wd_cnt <= '0;
      else              wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_unit.sv
// Self-checking bench for cpu_bus_unit: vector table, corner sequences,
// and a randomized run against a transaction-level memory/arbiter model.
module tb_cpu_bus_unit;

  localparam int TMO = 8;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        ls_req;
  logic        ls_we;
  logic [15:0] ls_addr;
  logic [15:0] ls_wdata;
  logic [15:0] ls_rdata;
  logic        ls_done;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd_ctrl;
  logic        mem_wr_ctrl;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        err;
  logic        busy;

  int nvec = 0;
  int nerr = 0;
  int stray = 0;

  cpu_bus_unit #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_done     (if_done),
    .ls_req      (ls_req),
    .ls_we       (ls_we),
    .ls_addr     (ls_addr),
    .ls_wdata    (ls_wdata),
    .ls_rdata    (ls_rdata),
    .ls_done     (ls_done),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rd_ctrl (mem_rd_ctrl),
    .mem_wr_ctrl (mem_wr_ctrl),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .err         (err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          ls;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mdata;
    int          wt;
    logic [15:0] exp_rd;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0;
    ls_req = 1'b0;
    mem_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_strobe();
    int n = 0;
    while (!(mem_rd_ctrl || mem_wr_ctrl) && n < 10) begin
      step();
      if (if_done || ls_done) stray++;
      n++;
    end
    chk("strobe_wait", mem_rd_ctrl | mem_wr_ctrl, 1);
  endtask

  task automatic run_single(input vec_t v);
    int cyc;
    if_addr  = v.addr;
    ls_addr  = v.addr;
    ls_we    = v.we;
    ls_wdata = v.wdata;
    if_req   = !v.ls;
    ls_req   = v.ls;
    step();
    chk("t_rd", mem_rd_ctrl, !v.we);
    chk("t_wr", mem_wr_ctrl, v.we);
    chk("t_addr", mem_addr, v.addr);
    chk("t_busy", busy, 1);
    if (v.we) chk("t_wdata", mem_wdata, v.wdata);
    cyc = 0;
    while ((mem_rd_ctrl || mem_wr_ctrl) && cyc < 40) begin
      cyc++;
      mem_ack   = (cyc == v.wt + 1);
      mem_rdata = mem_ack ? v.mdata : 16'hDEAD;
      step();
    end
    mem_ack = 1'b0;
    chk("t_strobe_len", cyc, v.wt + 1);
    chk("t_done", {if_done, ls_done}, v.ls ? 2'b01 : 2'b10);
    chk("t_rdata", v.ls ? ls_rdata : if_rdata, v.exp_rd);
    chk("t_err", err, 0);
    if_req = 1'b0;
    ls_req = 1'b0;
    step();
    chk("t_idle", {busy, if_done, ls_done}, 0);
  endtask

  vec_t        tbl [6];
  logic [15:0] mem  [16];
  logic [15:0] gold [16];

  initial begin
    bit          exp_g;
    bit          exp_last;
    bit          cur_port;
    bit          g;
    bit          ack_last;
    bit          strobe;
    bit          strobe_prev;
    int          wl;
    int          n_if;
    int          n_ls;
    logic [15:0] ls_hold;

    tbl[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5C3, 0, 16'hA5C3};
    tbl[1] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1, 16'hBEEF};
    tbl[2] = '{1'b1, 1'b1, 16'h0200, 16'h1234, 16'h7777, 4, 16'hBEEF};
    tbl[3] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0F0F, 2, 16'h0F0F};
    tbl[4] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h8001, 0, 16'h8001};
    tbl[5] = '{1'b1, 1'b1, 16'h0001, 16'hFFFF, 16'h0000, 0, 16'h8001};

    rst = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    ls_req = 1'b0;
    ls_we = 1'b0;
    ls_addr = '0;
    ls_wdata = '0;
    mem_rdata = '0;
    mem_ack = 1'b0;

    do_reset();
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_strobes", {mem_rd_ctrl, mem_wr_ctrl}, 0);
    chk("rst_done", {if_done, ls_done}, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);

    for (int i = 0; i < 6; i++) run_single(tbl[i]);

    // tie: grants must alternate LS, IF, LS, IF after reset
    do_reset();
    if_addr = 16'h0123;
    ls_addr = 16'h0ABC;
    ls_we   = 1'b0;
    if_req  = 1'b1;
    ls_req  = 1'b1;
    exp_g = 1'b1;
    n_if = 0;
    n_ls = 0;
    stray = 0;
    for (int k = 0; k < 4; k++) begin
      wait_strobe();
      chk("tie_addr", mem_addr, exp_g ? 16'h0ABC : 16'h0123);
      mem_ack = 1'b1;
      mem_rdata = 16'h5A00 + 16'(k);
      step();
      mem_ack = 1'b0;
      n_if += int'(if_done);
      n_ls += int'(ls_done);
      chk("tie_done", {if_done, ls_done}, exp_g ? 2'b01 : 2'b10);
      exp_g = !exp_g;
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    step();
    if (if_done || ls_done) stray++;
    chk("tie_counts", {16'(n_if), 16'(n_ls)}, {16'd2, 16'd2});
    chk("tie_stray", stray, 0);

    // reset in the middle of an LS load
    ls_addr = 16'h0777;
    ls_we = 1'b0;
    ls_req = 1'b1;
    step();
    chk("mr_rd", mem_rd_ctrl, 1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ls_req = 1'b0;
    chk("mr_clear", {mem_rd_ctrl, mem_wr_ctrl, busy,
                     if_done, ls_done, err}, 0);
    chk("mr_rdata", {if_rdata, ls_rdata}, 0);
    step();
    chk("mr_no_done", {if_done, ls_done}, 0);
    if_addr = 16'h0123;
    ls_addr = 16'h0ABC;
    if_req = 1'b1;
    ls_req = 1'b1;
    step();
    chk("mr_tie_ls", mem_addr, 16'h0ABC);
    mem_ack = 1'b1;
    mem_rdata = 16'h3C3C;
    step();
    mem_ack = 1'b0;
    chk("mr_tie_done", {if_done, ls_done}, 2'b01);
    if_req = 1'b0;
    ls_req = 1'b0;
    step();
    step();

    // back-to-back fetch with req held through done
    if_addr = 16'h0100;
    if_req = 1'b1;
    step();
    mem_ack = 1'b1;
    mem_rdata = 16'h1111;
    step();
    chk("b2b_done1", {if_done, if_rdata}, {1'b1, 16'h1111});
    if_addr = 16'h0102;
    mem_rdata = 16'h9999;
    step();
    chk("b2b_idle", {mem_rd_ctrl, busy, if_done}, 0);
    mem_ack = 1'b0;
    step();
    chk("b2b_second", {mem_rd_ctrl, mem_addr}, {1'b1, 16'h0102});
    mem_ack = 1'b1;
    mem_rdata = 16'h2222;
    step();
    mem_ack = 1'b0;
    chk("b2b_done2", {if_done, if_rdata}, {1'b1, 16'h2222});
    if_req = 1'b0;
    step();

`ifdef BUS_TIMEOUT_EN
    begin
      int n;
      ls_addr = 16'h0300;
      ls_we = 1'b0;
      ls_req = 1'b1;
      step();
      n = 0;
      while (!ls_done && n < 30) begin
        step();
        n++;
      end
      chk("tmo_latency", n, TMO + 1);
      chk("tmo_err", {ls_done, err}, 2'b11);
      chk("tmo_fill", ls_rdata, 16'hFFFF);
      ls_req = 1'b0;
      step();
      chk("tmo_err_pulse", err, 0);
      ls_req = 1'b1;
      step();
      for (int i = 0; i < TMO; i++) step();
      chk("tmo_still_acc", mem_rd_ctrl, 1);
      mem_ack = 1'b1;
      mem_rdata = 16'h4321;
      step();
      mem_ack = 1'b0;
      chk("tmo_ack_wins", {ls_done, err}, 2'b10);
      chk("tmo_ack_data", ls_rdata, 16'h4321);
      ls_req = 1'b0;
      step();
    end
`endif

    // randomized traffic against the memory/arbiter model
    do_reset();
    for (int i = 0; i < 16; i++) begin
      mem[i] = 16'($urandom);
      gold[i] = mem[i];
    end
    exp_last = 1'b0;
    cur_port = 1'b0;
    ack_last = 1'b0;
    strobe_prev = 1'b0;
    wl = 0;
    ls_hold = 16'h0000;
    for (int c = 0; c < 800; c++) begin
      step();
      strobe = mem_rd_ctrl | mem_wr_ctrl;
      chk("r_done", {if_done, ls_done},
          ack_last ? (cur_port ? 2'b01 : 2'b10) : 2'b00);
      chk("r_err", err, 0);
      if (ack_last && !cur_port) begin
        chk("r_if_rdata", if_rdata, gold[if_addr[3:0]]);
        if_req = 1'($urandom_range(0, 1));
        if_addr = 16'($urandom);
      end
      if (ack_last && cur_port) begin
        if (ls_we) gold[ls_addr[3:0]] = ls_wdata;
        else       ls_hold = gold[ls_addr[3:0]];
        chk("r_ls_rdata", ls_rdata, ls_hold);
        ls_req = 1'($urandom_range(0, 1));
        ls_we = 1'($urandom_range(0, 1));
        ls_addr = 16'($urandom);
        ls_wdata = 16'($urandom);
      end
      if (strobe && !strobe_prev) begin
        g = (if_req && ls_req) ? !exp_last : ls_req;
        chk("r_grant_addr", mem_addr, g ? ls_addr : if_addr);
        chk("r_grant_dir", {mem_rd_ctrl, mem_wr_ctrl},
            (g && ls_we) ? 2'b01 : 2'b10);
        if (g && ls_we) chk("r_wdata", mem_wdata, ls_wdata);
        exp_last = g;
        cur_port = g;
        wl = $urandom_range(0, 3);
      end
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1;
        if_addr = 16'($urandom);
      end
      if (!ls_req && $urandom_range(0, 3) == 0) begin
        ls_req = 1'b1;
        ls_we = 1'($urandom_range(0, 1));
        ls_addr = 16'($urandom);
        ls_wdata = 16'($urandom);
      end
      if (strobe) begin
        if (wl == 0) begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr[3:0]];
          if (mem_wr_ctrl) mem[mem_addr[3:0]] = mem_wdata;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = 16'($urandom);
          wl--;
        end
      end else begin
        mem_ack = ($urandom_range(0, 3) == 0);
        mem_rdata = 16'($urandom);
      end
      ack_last = strobe && mem_ack;
      strobe_prev = strobe;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
